ppdu_sequencer: RTL and testbench

PPDU_SEQUENCER -- requirements
Module: ppdu_sequencer

---
 rtl/ppdu_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_ppdu_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ppdu_sequencer.sv
// Serial PPDU framer: preamble, SIGNAL field, SERVICE, PSDU data, tail and symbol padding.
// One frame bit is emitted per cycle and appears on the registered BitOut on the next edge.
module ppdu_sequencer #(
  parameter int PREAMBLE_BITS = 96
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [3:0]  Rate,
  input  logic [11:0] Length,
  input  logic        DataIn,
  input  logic        DataValid,
  output logic        DataReq,
  output logic        BitOut,
  output logic        BitValid,
  output logic        ScrambleEn,
  output logic        ScrambleInit,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);

  typedef enum logic [3:0] {
    IDLE, PREAMBLE, SIG_RATE, SIG_RSVD, SIG_LENGTH, SIG_PARITY,
    SIG_TAIL, SERVICE, DATA, TAIL, PAD
  } state_t;

  localparam logic [14:0] PRE_LAST = 15'(PREAMBLE_BITS - 1);

  state_t      state;
  logic [14:0] bit_cnt;
  logic [14:0] data_total;
  logic [14:0] data_last;
  logic [3:0]  rate_q;
  logic [11:0] len_sh;
  logic        parity;
  logic [7:0]  sym_cnt;
  logic [7:0]  sym_inc;
  logic [7:0]  sym_next;
  logic [7:0]  n_dbps;
  logic        sym_wrap;

  // Data bits per OFDM symbol; zero marks an unsupported rate code.
  function automatic logic [7:0] dbps_of(input logic [3:0] r);
    case (r)
      4'b1101: dbps_of = 8'd24;
      4'b1111: dbps_of = 8'd36;
      4'b0101: dbps_of = 8'd48;
      4'b0111: dbps_of = 8'd72;
      4'b1001: dbps_of = 8'd96;
      4'b1011: dbps_of = 8'd144;
      4'b0001: dbps_of = 8'd192;
      4'b0011: dbps_of = 8'd216;
      default: dbps_of = 8'd0;
    endcase
  endfunction

  assign n_dbps    = dbps_of(rate_q);
  assign sym_inc   = sym_cnt + 8'd1;
  assign sym_wrap  = (sym_inc == n_dbps);
  assign sym_next  = sym_wrap ? 8'd0 : sym_inc;
  assign data_last = data_total - 15'd1;
  assign DataReq   = (state == DATA);

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      data_total   <= '0;
      rate_q       <= '0;
      len_sh       <= '0;
      parity       <= 1'b0;
      sym_cnt      <= '0;
      BitOut       <= 1'b0;
      BitValid     <= 1'b0;
      ScrambleEn   <= 1'b0;
      ScrambleInit <= 1'b0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Error        <= 1'b0;
    end else begin
      BitOut       <= 1'b0;
      BitValid     <= 1'b0;
      ScrambleEn   <= 1'b0;
      ScrambleInit <= 1'b0;
      Done         <= 1'b0;
      Error        <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            if (dbps_of(Rate) != 8'd0 && Length != 12'd0) begin
              rate_q     <= Rate;
              len_sh     <= Length;
              data_total <= {Length, 3'b000};
              parity     <= ^{Rate, Length};
              bit_cnt    <= '0;
              Busy       <= 1'b1;
              state      <= PREAMBLE;
            end else begin
              Error <= 1'b1;
            end
          end
        end
        PREAMBLE: begin
          BitValid <= 1'b1;
          BitOut   <= ~bit_cnt[0];
          if (bit_cnt == PRE_LAST) begin
            bit_cnt <= '0;
            state   <= SIG_RATE;
          end else begin
            bit_cnt <= bit_cnt + 15'd1;
          end
        end
        SIG_RATE: begin
          BitValid <= 1'b1;
          BitOut   <= rate_q[~bit_cnt[1:0]];
          if (bit_cnt == 15'd3) begin
            bit_cnt <= '0;
            state   <= SIG_RSVD;
          end else begin
            bit_cnt <= bit_cnt + 15'd1;
          end
        end
        SIG_RSVD: begin
          BitValid <= 1'b1;
          state    <= SIG_LENGTH;
        end
        // Length goes out LSB first, so shift it down one bit per cycle.
        SIG_LENGTH: begin
          BitValid <= 1'b1;
          BitOut   <= len_sh[0];
          len_sh   <= len_sh >> 1;
          if (bit_cnt == 15'd11) begin
            bit_cnt <= '0;
            state   <= SIG_PARITY;
          end else begin
            bit_cnt <= bit_cnt + 15'd1;
          end
        end
        SIG_PARITY: begin
          BitValid <= 1'b1;
          BitOut   <= parity;
          state    <= SIG_TAIL;
        end
        SIG_TAIL: begin
          BitValid <= 1'b1;
          if (bit_cnt == 15'd5) begin
            bit_cnt <= '0;
            sym_cnt <= '0;
            state   <= SERVICE;
          end else begin
            bit_cnt <= bit_cnt + 15'd1;
          end
        end
        SERVICE: begin
          BitValid     <= 1'b1;
          ScrambleEn   <= 1'b1;
          ScrambleInit <= (bit_cnt == 15'd0);
          sym_cnt      <= sym_next;
          if (bit_cnt == 15'd15) begin
            bit_cnt <= '0;
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 15'd1;
          end
        end
        DATA: begin
          if (DataValid) begin
            BitValid   <= 1'b1;
            BitOut     <= DataIn;
            ScrambleEn <= 1'b1;
            sym_cnt    <= sym_next;
            if (bit_cnt == data_last) begin
              bit_cnt <= '0;
              state   <= TAIL;
            end else begin
              bit_cnt <= bit_cnt + 15'd1;
            end
          end
        end
        // A frame that already ends on a symbol boundary skips padding.
        TAIL: begin
          BitValid <= 1'b1;
          sym_cnt  <= sym_next;
          if (bit_cnt == 15'd5) begin
            bit_cnt <= '0;
            if (sym_wrap) begin
              Done  <= 1'b1;
              Busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= PAD;
            end
          end else begin
            bit_cnt <= bit_cnt + 15'd1;
          end
        end
        PAD: begin
          BitValid   <= 1'b1;
          ScrambleEn <= 1'b1;
          sym_cnt    <= sym_next;
          if (sym_wrap) begin
            Done  <= 1'b1;
            Busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppdu_sequencer.sv
// Scoreboard bench for ppdu_sequencer: a frame model queues expected bits, a monitor pops them.
module tb_ppdu_sequencer;

  localparam int PRE = 96;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [3:0]  Rate = 4'd0;
  logic [11:0] Length = 12'd0;
  logic        DataIn = 1'b0;
  logic        DataValid = 1'b0;
  logic        DataReq, BitOut, BitValid, ScrambleEn, ScrambleInit, Busy, Done, Error;

  typedef struct packed {
    logic b;
    logic se;
    logic si;
    logic done;
  } exp_t;

  exp_t exp_q[$];
  bit   src_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   stall_pct = 0;
  int   force_stall = 0;
  bit   consumed = 1'b0;
  bit   stall_cur = 1'b0;

  ppdu_sequencer #(.PREAMBLE_BITS(PRE)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Rate(Rate), .Length(Length),
    .DataIn(DataIn), .DataValid(DataValid), .DataReq(DataReq), .BitOut(BitOut),
    .BitValid(BitValid), .ScrambleEn(ScrambleEn), .ScrambleInit(ScrambleInit),
    .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 Clock = ~Clock;

  function automatic int dbps(input logic [3:0] r);
    case (r)
      4'b1101: return 24;
      4'b1111: return 36;
      4'b0101: return 48;
      4'b0111: return 72;
      4'b1001: return 96;
      4'b1011: return 144;
      4'b0001: return 192;
      4'b0011: return 216;
      default: return 0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void pushBit(input logic b, input logic se, input logic si);
    exp_t e;
    e.b = b; e.se = se; e.si = si; e.done = 1'b0;
    exp_q.push_back(e);
  endfunction

  // Builds the whole expected frame from the field layout and symbol arithmetic.
  function automatic void pushFrame(input logic [3:0] r, input int len);
    int   n = dbps(r);
    int   used = 16 + 8 * len + 6;
    int   pad = (n - (used % n)) % n;
    logic par = 1'b0;
    exp_t last;
    for (int i = 0; i < PRE; i++) pushBit(((i % 2) == 0), 1'b0, 1'b0);
    for (int i = 3; i >= 0; i--) begin pushBit(r[i], 1'b0, 1'b0); par ^= r[i]; end
    pushBit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      logic lb = ((len >> i) & 1) != 0;
      pushBit(lb, 1'b0, 1'b0);
      par ^= lb;
    end
    pushBit(par, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) pushBit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) pushBit(1'b0, 1'b1, (i == 0));
    for (int i = 0; i < 8 * len; i++) begin
      bit d = 1'($urandom_range(1));
      src_q.push_back(d);
      pushBit(d, 1'b1, 1'b0);
    end
    for (int i = 0; i < 6; i++) pushBit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < pad; i++) pushBit(1'b0, 1'b1, 1'b0);
    last = exp_q.pop_back();
    last.done = 1'b1;
    exp_q.push_back(last);
  endfunction

  task automatic applyStimulus(input logic [3:0] r, input int len, input int pct);
    stall_pct = pct;
    pushFrame(r, len);
    @(negedge Clock);
    Start = 1'b1; Rate = r; Length = 12'(len);
    @(negedge Clock);
    Start = 1'b0; Rate = 4'($urandom); Length = 12'($urandom);
  endtask

  task automatic waitFrame(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || Busy) && n < 20000) begin
      @(negedge Clock);
      n++;
    end
    checkOutput(name, {exp_q.size() == 0, Busy}, 2'b10);
  endtask

  task automatic waitDataReq();
    int n = 0;
    while (!DataReq && n < 2000) begin
      @(negedge Clock);
      n++;
    end
    checkOutput("reach_data", DataReq, 1);
  endtask

  task automatic rejectStart(input logic [3:0] r, input logic [11:0] len);
    @(negedge Clock);
    Start = 1'b1; Rate = r; Length = len;
    @(negedge Clock);
    Start = 1'b0;
    checkOutput("reject_error", Error, 1);
    checkOutput("reject_busy", Busy, 0);
    @(negedge Clock);
    checkOutput("reject_error_pulse", Error, 0);
    checkOutput("reject_idle", {Busy, BitValid}, 0);
  endtask

  // Source model: presents the next PSDU bit and randomly withholds DataValid.
  initial begin
    forever begin
      @(negedge Clock);
      if (consumed && src_q.size() > 0) void'(src_q.pop_front());
      if (DataReq && force_stall > 0) begin
        DataValid = 1'b0;
        force_stall--;
      end else begin
        DataValid = ($urandom_range(99) >= stall_pct);
      end
      DataIn    = (DataReq && src_q.size() > 0) ? src_q[0] : 1'($urandom_range(1));
      consumed  = DataReq && DataValid;
      stall_cur = DataReq && !DataValid;
    end
  end

  // Monitor: every valid bit is matched against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clock);
      #1;
      if (stall_cur) checkOutput("stall_gap", BitValid, 0);
      if (BitValid) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL extra_bit: got bit %0b, expected none at %0t", BitOut, $time);
        end else begin
          e = exp_q.pop_front();
          checkOutput("frame_bit", {BitOut, ScrambleEn, ScrambleInit, Done}, e);
          checkOutput("busy_during_bit", Busy, !e.done);
        end
      end else begin
        checkOutput("flags_without_bit", {Done, ScrambleInit}, 0);
      end
    end
  end

  initial begin
    logic [3:0] good_rates [8] = '{4'b1101, 4'b1111, 4'b0101, 4'b0111,
                                   4'b1001, 4'b1011, 4'b0001, 4'b0011};
    logic [3:0] bad_rates [4] = '{4'b1000, 4'b0000, 4'b0110, 4'b1110};

    Reset = 1'b0; Start = 1'b1; Rate = 4'b1101; Length = 12'd1;
    repeat (3) @(negedge Clock);
    checkOutput("reset_outputs",
      {BitOut, BitValid, ScrambleEn, ScrambleInit, Busy, Done, Error, DataReq}, 0);
    Start = 1'b0; Reset = 1'b1;
    @(negedge Clock);
    checkOutput("no_start_in_reset", Busy, 0);

    $display("[TB] frame rate=1101 len=1");
    applyStimulus(4'b1101, 1, 0);
    waitFrame("frame_1101_len1");
    $display("[TB] frame rate=0011 len=100");
    applyStimulus(4'b0011, 100, 0);
    waitFrame("frame_0011_len100");
    $display("[TB] frame rate=1001 len=11 with stalls");
    applyStimulus(4'b1001, 11, 25);
    waitFrame("frame_1001_len11");

    $display("[TB] forced 5-cycle stall and Start while busy");
    applyStimulus(4'b0101, 6, 0);
    waitDataReq();
    repeat (10) @(negedge Clock);
    force_stall = 5;
    Start = 1'b1; Rate = 4'b1101; Length = 12'd3;
    @(negedge Clock);
    Start = 1'b0;
    waitFrame("frame_forced_stall");

    $display("[TB] rejected starts");
    rejectStart(4'b1101, 12'd0);
    foreach (bad_rates[i]) rejectStart(bad_rates[i], 12'(1 + $urandom_range(4094)));

    $display("[TB] reset during DATA");
    applyStimulus(4'b1111, 20, 10);
    waitDataReq();
    repeat (12) @(negedge Clock);
    Reset = 1'b0; Start = 1'b1; Rate = 4'b1101; Length = 12'd5;
    @(negedge Clock);
    checkOutput("midframe_reset_outputs",
      {BitOut, BitValid, ScrambleEn, ScrambleInit, Busy, Done, Error, DataReq}, 0);
    exp_q.delete();
    src_q.delete();
    @(negedge Clock);
    Start = 1'b0; Reset = 1'b1;
    @(negedge Clock);
    checkOutput("midframe_reset_idle", Busy, 0);
    applyStimulus(4'b1111, 20, 10);
    waitFrame("frame_after_reset");

    $display("[TB] random frames");
    for (int k = 0; k < 6; k++) begin
      applyStimulus(good_rates[$urandom_range(7)], 1 + $urandom_range(39), $urandom_range(40));
      waitFrame("frame_random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
